// File: rtl/seq_multiplier_if.sv
// Valid/ready operand and product channels for the sequential multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface seq_multiplier_if #(
    parameter int unsigned M = 26,
    parameter int unsigned N = 14
);
    localparam int unsigned P = M + N;

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] product;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add unsigned multiplier: one multiplier bit per clock,
// a single (M+N)-bit adder, fixed N-cycle compute latency.
module seq_multiplier #(
    parameter int unsigned M = 26,
    parameter int unsigned N = 14
) (
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);
    localparam int unsigned P  = M + N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [P-1:0]   areg_q, areg_d;
    logic [N-1:0]   mreg_q, mreg_d;
    logic [P-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [P-1:0]   prod_q, prod_d;
    logic           ovalid_q, ovalid_d;
    logic [P-1:0]   acc_sum;

    // Product of two unsigned operands always fits in P bits, so no carry-out.
    assign acc_sum = acc_q + (mreg_q[0] ? areg_q : P'(0));

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = ovalid_q;
    assign bus.product   = prod_q;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        mreg_d   = mreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        ovalid_d = ovalid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    areg_d  = P'(bus.multiplicand);
                    mreg_d  = bus.multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_sum;
                areg_d = areg_q << 1;
                mreg_d = mreg_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    prod_d   = acc_sum;
                    ovalid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            areg_q   <= '0;
            mreg_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            mreg_q   <= mreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            ovalid_q <= ovalid_d;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table plus
// hand-written stall, mid-operation reset and back-to-back sequences.
module tb_seq_multiplier;
    localparam int unsigned M = 26;
    localparam int unsigned N = 14;
    localparam int unsigned P = M + N;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seq_multiplier_if #(.M(M), .N(N)) bus ();
    seq_multiplier #(.M(M), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] a;
        logic [N-1:0] b;
        logic [P-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept operands, then wait for the result without acknowledging it.
    task automatic start_op(input logic [M-1:0] a, input logic [N-1:0] b,
                            input logic [P-1:0] exp, input string name);
        int wait_cyc;
        int lat;
        logic ir_seen;
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        wait_cyc = 0;
        while (!bus.in_ready && wait_cyc < 100) begin
            tick();
            wait_cyc++;
        end
        chk({name, " accept_wait"}, 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid     = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
        lat = 0;
        ir_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) ir_seen = 1'b1;
            tick();
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(N));
        chk({name, " in_ready_calc"}, 64'(ir_seen), 64'(0));
        chk({name, " in_ready_done"}, 64'(bus.in_ready), 64'(0));
        chk({name, " product"}, 64'(bus.product), 64'(exp));
    endtask

    task automatic finish_op(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({name, " out_valid_clr"}, 64'(bus.out_valid), 64'(0));
        chk({name, " in_ready_idle"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic [P-1:0] expq [$];
        logic [P-1:0] held;
        int cyc;
        int last_acc;
        int nres;
        logic acc_now;

        vecs[0] = '{a: 26'd3,        b: 14'd5,      exp: 40'd15};
        vecs[1] = '{a: 26'h3FFFFFF,  b: 14'h3FFF,   exp: 40'hFF_FBFF_C001};
        vecs[2] = '{a: 26'd0,        b: 14'h1234,   exp: 40'd0};
        vecs[3] = '{a: 26'h1234,     b: 14'd0,      exp: 40'd0};
        vecs[4] = '{a: 26'd100,      b: 14'd200,    exp: 40'd20000};
        vecs[5] = '{a: 26'hFF,       b: 14'hFF,     exp: 40'hFE01};
        vecs[6] = '{a: 26'h2000000,  b: 14'h2000,   exp: 40'h40_0000_0000};
        vecs[7] = '{a: 26'd7,        b: 14'h3FFF,   exp: 40'h1BFF9};
        vecs[8] = '{a: 26'h3FFFFFF,  b: 14'd1,      exp: 40'h3FFFFFF};
        vecs[9] = '{a: 26'd1,        b: 14'h3FFF,   exp: 40'h3FFF};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) tick();
        chk("reset out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset product", 64'(bus.product), 64'(0));
        chk("reset in_ready_in_rst", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("reset in_ready_after", 64'(bus.in_ready), 64'(1));

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i));
        end

        // Consumer stall with a new request pending.
        start_op(26'd11, 14'd13, 40'd143, "stall");
        held = bus.product;
        bus.in_valid = 1'b1;
        bus.multiplicand = 26'd6;
        bus.multiplier = 14'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall out_valid c%0d", i), 64'(bus.out_valid), 64'(1));
            chk($sformatf("stall product c%0d", i), 64'(bus.product), 64'(held));
            chk($sformatf("stall in_ready c%0d", i), 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("stall release out_valid", 64'(bus.out_valid), 64'(0));
        chk("stall release in_ready", 64'(bus.in_ready), 64'(1));
        start_op(26'd6, 14'd9, 40'd54, "stall_next");
        finish_op("stall_next");

        // Reset in the middle of CALC.
        bus.in_valid = 1'b1;
        bus.multiplicand = 26'd12345;
        bus.multiplier = 14'd321;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk("midrst in_ready_in_rst", 64'(bus.in_ready), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("midrst out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst product", 64'(bus.product), 64'(0));
        chk("midrst in_ready", 64'(bus.in_ready), 64'(1));
        repeat (N + 2) begin
            tick();
            if (bus.out_valid) chk("midrst stray out_valid", 64'(bus.out_valid), 64'(0));
        end
        start_op(26'd100, 14'd200, 40'd20000, "post_rst");
        finish_op("post_rst");

        // Back-to-back random operands with always-ready consumer.
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.multiplicand = M'($urandom);
        bus.multiplier = N'($urandom);
        cyc = 0;
        last_acc = -1;
        nres = 0;
        while (nres < 1000 && cyc < 20000) begin
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now) begin
                expq.push_back(P'(64'(bus.multiplicand) * 64'(bus.multiplier)));
                if (last_acc >= 0) chk("b2b spacing", 64'(cyc - last_acc), 64'(N + 2));
                last_acc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("b2b unexpected result", 64'(bus.product), 64'(0));
                end else begin
                    chk($sformatf("b2b product %0d", nres), 64'(bus.product), 64'(expq.pop_front()));
                end
                nres++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                bus.multiplicand = M'($urandom);
                bus.multiplier = N'($urandom);
            end
        end
        chk("b2b result count", 64'(nres), 64'(1000));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
